// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS boot loader: FSM state codes and frame geometry.
package mips_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_CNT_LO = 3'd1;
    localparam state_t S_CNT_HI = 3'd2;
    localparam state_t S_DATA   = 3'd3;
    localparam state_t S_CSUM   = 3'd4;
    localparam state_t S_DONE   = 3'd5;
    localparam state_t S_ERR    = 3'd6;

    localparam int CNT_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // States in which the loader presents rx_ready.
    function automatic logic takes_bytes(input state_t s);
        return (s == S_CNT_LO) || (s == S_CNT_HI) || (s == S_DATA) || (s == S_CSUM);
    endfunction

endpackage

// File: rtl/mips_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface mips_boot_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/mips_boot_loader_word_assembler.sv
// Packs accepted DATA bytes into little-endian words and keeps the running XOR checksum.
module word_assembler
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic        word_valid,
    output logic [31:0] word,
    output logic [7:0]  csum
);

    logic [1:0]  byte_cnt;
    logic [23:0] held;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt <= '0;
            held     <= '0;
            csum     <= '0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            held     <= {data, held[23:8]};
            csum     <= csum ^ data;
        end
    end

    // The three held bytes plus the byte being accepted form the word, so the
    // top level can register it on the same edge that takes the fourth byte.
    assign word_valid = accept && (byte_cnt == 2'(BYTES_PER_WORD - 1));
    assign word       = {data, held};

endmodule

// File: rtl/mips_boot_loader.sv
// Framed byte-stream loader for the MIPS instruction memory; holds the core in reset
// until a checksum-verified load completes. Optional idle timeout: LOADER_TIMEOUT_EN.
module mips_boot_loader
    import mips_pkg::*;
#(
    parameter int IMEM_DEPTH     = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic          clk,
    input  logic          reset,
    mips_boot_loader_if.slave bus,
    output logic          cpu_reset,
    output logic          load_done,
    output logic          load_error
);

    state_t      state;
    logic [7:0]  cnt_lo;
    logic [15:0] n_words;
    logic [15:0] word_index;
    logic [15:0] n_next;
    logic        accept;
    logic        word_valid;
    logic [31:0] word;
    logic [7:0]  csum;
    logic        timed_out;

    assign bus.rx_ready = takes_bytes(state);
    assign accept       = bus.rx_valid && bus.rx_ready;
    assign n_next       = {bus.rx_data, cnt_lo};

    word_assembler u_word_assembler (
        .clk        (clk),
        .reset      (reset),
        .accept     (accept && (state == S_DATA)),
        .data       (bus.rx_data),
        .word_valid (word_valid),
        .word       (word),
        .csum       (csum)
    );

`ifdef LOADER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    // Idle in S_CNT_LO is not counted: the host may take as long as it likes to start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (accept || !((state == S_CNT_HI) || (state == S_DATA) || (state == S_CSUM))) begin
            idle_cnt <= '0;
        end else if (!timed_out) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timed_out = (idle_cnt == TW'(TIMEOUT_CYCLES));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            cnt_lo         <= '0;
            n_words        <= '0;
            word_index     <= '0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            cpu_reset      <= 1'b1;
            load_done      <= 1'b0;
            load_error     <= 1'b0;
        end else begin
            // NOTE: non-blocking updates mean imem_addr captures word_index before
            // its increment on the same edge, giving address = index*4 of this word.
            bus.imem_we <= word_valid;
            if (word_valid) begin
                bus.imem_addr  <= {14'd0, word_index, 2'b00};
                bus.imem_wdata <= word;
                word_index     <= word_index + 16'd1;
            end

            if (timed_out) begin
                state      <= S_ERR;
                load_error <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: state <= S_CNT_LO;
                    S_CNT_LO: if (accept) begin
                        cnt_lo <= bus.rx_data;
                        state  <= S_CNT_HI;
                    end
                    S_CNT_HI: if (accept) begin
                        n_words <= n_next;
                        if ({16'd0, n_next} > 32'(IMEM_DEPTH)) begin
                            state      <= S_ERR;
                            load_error <= 1'b1;
                        end else if (n_next == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                    S_DATA: if (word_valid && (word_index == n_words - 16'd1)) begin
                        state <= S_CSUM;
                    end
                    S_CSUM: if (accept) begin
                        if (bus.rx_data == csum) begin
                            state     <= S_DONE;
                            load_done <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            state      <= S_ERR;
                            load_error <= 1'b1;
                        end
                    end
                    default: ;  // S_DONE / S_ERR are terminal until reset
                endcase
            end
        end
    end

endmodule
